gesture_pose_sequencer: RTL and testbench

- Maps classifier gesture codes to per-channel servo pulse widths for the bionic hand.
- Sits between the gesture classifier and the downstream `servo_pwm` instances.
- Generalises fixed five-finger decoding to `NUM_CH` channels and `NUM_GESTURES` poses held in a pose table.
- Adds a valid/ready handshake, frame-aligned slew limiting, and an inactivity timeout that returns the hand to neutral.

---
 rtl/gesture_pkg.sv | 29 ++
 rtl/gesture_pose_sequencer_servo_slew.sv | 56 +++++
 rtl/gesture_pose_sequencer.sv | 208 ++++++++++++++++++++
 tb/tb_gesture_pose_sequencer.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/gesture_pkg.sv
// Shared types and helpers for the gesture pose sequencer: width type,
// sequencer states, default pose table contents and width clamping.
package gesture_pkg;

   typedef logic [15:0] width_t;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_LOAD = 2'd1,
      S_RAMP = 2'd2
   } state_t;

   // Row g of the power-up pose table: each step closes the hand by 100 us.
   function automatic width_t default_pose(input int g, input int w_neutral, input int w_min);
      int v;
      v = w_neutral - 100 * g;
      if (v < w_min) v = w_min;
      return width_t'(v);
   endfunction

   function automatic width_t clamp_width(input width_t w, input int w_min, input int w_max);
      int v;
      v = int'(w);
      if (v < w_min) v = w_min;
      else if (v > w_max) v = w_max;
      return width_t'(v);
   endfunction

endpackage

// File: rtl/gesture_pose_sequencer_servo_slew.sv
// One servo channel: current/target width registers and the per-frame
// slew step that moves the current width toward the target.
module servo_slew
   import gesture_pkg::*;
#(
   parameter int STEP_US   = 10,
   parameter int W_NEUTRAL = 1500
) (
   input  logic   clk,
   input  logic   rst,
   input  logic   tick,
   input  logic   load,
   input  width_t target_in,
   output width_t cur,
   output width_t cur_next,
   output logic   done
);

   localparam logic signed [16:0] STEP = STEP_US[16:0];

   width_t cur_q, cur_d;
   width_t target_q, target_d;
   logic signed [16:0] diff;

   // A tick in the same cycle as a load still slews toward the old target.
   always_comb begin
      diff     = $signed({1'b0, target_q}) - $signed({1'b0, cur_q});
      cur_d    = cur_q;
      target_d = target_q;
      if (tick) begin
         if (diff > STEP)
            cur_d = cur_q + width_t'(STEP_US);
         else if (diff < -STEP)
            cur_d = cur_q - width_t'(STEP_US);
         else
            cur_d = target_q;
      end
      if (load)
         target_d = target_in;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cur_q    <= width_t'(W_NEUTRAL);
         target_q <= width_t'(W_NEUTRAL);
      end else begin
         cur_q    <= cur_d;
         target_q <= target_d;
      end
   end

   assign cur      = cur_q;
   assign cur_next = cur_d;
   assign done     = (cur_q == target_q);

endmodule

// File: rtl/gesture_pose_sequencer.sv
// Maps classifier gesture codes to slew-limited per-channel servo widths.
// Define GESTURE_TABLE_WR_EN to make the pose table writable via tbl_*.
module gesture_pose_sequencer
   import gesture_pkg::*;
#(
   parameter int NUM_CH         = 5,
   parameter int NUM_GESTURES   = 8,
   parameter int CLK_HZ         = 50_000_000,
   parameter int FRAME_US       = 20000,
   parameter int STEP_US        = 10,
   parameter int TIMEOUT_FRAMES = 50,
   parameter int W_MIN          = 1000,
   parameter int W_MAX          = 2000,
   parameter int W_NEUTRAL      = 1500,
   localparam int IDXW = (NUM_GESTURES > 1) ? $clog2(NUM_GESTURES) : 1,
   localparam int CHW  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 gesture_valid,
   input  logic [7:0]           gesture,
   output logic                 gesture_ready,
   input  logic                 tbl_we,
   input  logic [IDXW-1:0]      tbl_idx,
   input  logic [CHW-1:0]       tbl_ch,
   input  logic [15:0]          tbl_width,
   output logic [NUM_CH*16-1:0] width_us,
   output logic                 frame_tick,
   output logic                 settled,
   output logic                 unknown,
   output logic                 timeout
);

   localparam int FRAME_CYC = CLK_HZ / 1_000_000 * FRAME_US;
   localparam int FW        = (FRAME_CYC > 1) ? $clog2(FRAME_CYC) : 1;
   localparam logic [FW-1:0] FRAME_RELOAD = FW'(FRAME_CYC - 1);
   localparam int TW        = $clog2(TIMEOUT_FRAMES + 1);
   localparam logic [TW-1:0] TMO_MAX = TW'(TIMEOUT_FRAMES);

   state_t          state_q, state_d;
   logic [FW-1:0]   frame_cnt_q, frame_cnt_d;
   logic            frame_tick_q, frame_tick_d;
   logic [TW-1:0]   tmo_cnt_q, tmo_cnt_d;
   logic            timeout_q, timeout_d;
   logic            unknown_q, unknown_d;
   logic [7:0]      gesture_q, gesture_d;
   logic            neutral_q, neutral_d;
   logic            pend_q, pend_d;

   logic            accept;
   logic            tmo_fire;
   logic            code_known;
   logic            slew_load;
   logic            any_diff;
   logic [NUM_CH-1:0] done;
   width_t          cur      [NUM_CH];
   width_t          cur_next [NUM_CH];
   width_t          tgt_new  [NUM_CH];

   assign gesture_ready = (state_q != S_LOAD);
   assign accept        = gesture_valid && gesture_ready;
   assign code_known    = (32'(gesture_q) < NUM_GESTURES);

   // The tick is registered so it lines up with the counter reading zero
   // while still being low straight out of reset.
   always_comb begin
      frame_cnt_d  = (frame_cnt_q == '0) ? FRAME_RELOAD : frame_cnt_q - 1'b1;
      frame_tick_d = (frame_cnt_d == '0);
   end

   always_comb begin
      tmo_cnt_d = tmo_cnt_q;
      timeout_d = timeout_q;
      tmo_fire  = 1'b0;
      if (accept) begin
         tmo_cnt_d = '0;
         timeout_d = 1'b0;
      end else if (frame_tick_q && (tmo_cnt_q != TMO_MAX)) begin
         tmo_cnt_d = tmo_cnt_q + 1'b1;
         if (tmo_cnt_d == TMO_MAX) begin
            timeout_d = 1'b1;
            tmo_fire  = 1'b1;
         end
      end
   end

`ifdef GESTURE_TABLE_WR_EN
   width_t tbl_q [NUM_GESTURES][NUM_CH];
   width_t tbl_d [NUM_GESTURES][NUM_CH];

   always_comb begin
      tbl_d = tbl_q;
      if (tbl_we && (32'(tbl_idx) < NUM_GESTURES) && (32'(tbl_ch) < NUM_CH))
         tbl_d[tbl_idx][tbl_ch] = clamp_width(tbl_width, W_MIN, W_MAX);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int g = 0; g < NUM_GESTURES; g++)
            for (int c = 0; c < NUM_CH; c++)
               tbl_q[g][c] <= default_pose(g, W_NEUTRAL, W_MIN);
      end else begin
         tbl_q <= tbl_d;
      end
   end
`else
   logic tbl_unused;
   assign tbl_unused = ^{tbl_we, tbl_idx, tbl_ch, tbl_width};
`endif

   // The table is read in the load cycle, so a coincident write lands after.
   always_comb begin
      for (int c = 0; c < NUM_CH; c++) begin
         tgt_new[c] = width_t'(W_NEUTRAL);
         if (!neutral_q && code_known)
`ifdef GESTURE_TABLE_WR_EN
            tgt_new[c] = tbl_q[gesture_q[IDXW-1:0]][c];
`else
            tgt_new[c] = default_pose(int'(gesture_q), W_NEUTRAL, W_MIN);
`endif
      end
   end

   always_comb begin
      any_diff = 1'b0;
      for (int c = 0; c < NUM_CH; c++)
         if (tgt_new[c] != cur_next[c]) any_diff = 1'b1;
   end

   // An accept always wins over a pending timeout retarget.
   always_comb begin
      state_d   = state_q;
      gesture_d = gesture_q;
      neutral_d = neutral_q;
      unknown_d = unknown_q;
      pend_d    = pend_q || tmo_fire;
      slew_load = 1'b0;
      case (state_q)
         S_IDLE, S_RAMP: begin
            if (accept) begin
               state_d   = S_LOAD;
               gesture_d = gesture;
               neutral_d = 1'b0;
               unknown_d = (32'(gesture) >= NUM_GESTURES);
               pend_d    = 1'b0;
            end else if (pend_q || tmo_fire) begin
               state_d   = S_LOAD;
               neutral_d = 1'b1;
               pend_d    = 1'b0;
            end else if ((state_q == S_RAMP) && (&done)) begin
               state_d = S_IDLE;
            end
         end
         S_LOAD: begin
            slew_load = 1'b1;
            state_d   = any_diff ? S_RAMP : S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= S_IDLE;
         frame_cnt_q  <= '0;
         frame_tick_q <= 1'b0;
         tmo_cnt_q    <= '0;
         timeout_q    <= 1'b0;
         unknown_q    <= 1'b0;
         gesture_q    <= '0;
         neutral_q    <= 1'b1;
         pend_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         frame_cnt_q  <= frame_cnt_d;
         frame_tick_q <= frame_tick_d;
         tmo_cnt_q    <= tmo_cnt_d;
         timeout_q    <= timeout_d;
         unknown_q    <= unknown_d;
         gesture_q    <= gesture_d;
         neutral_q    <= neutral_d;
         pend_q       <= pend_d;
      end
   end

   for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
      servo_slew #(
         .STEP_US   (STEP_US),
         .W_NEUTRAL (W_NEUTRAL)
      ) u_slew (
         .clk       (clk),
         .rst       (rst),
         .tick      (frame_tick_q),
         .load      (slew_load),
         .target_in (tgt_new[c]),
         .cur       (cur[c]),
         .cur_next  (cur_next[c]),
         .done      (done[c])
      );
      assign width_us[16*c +: 16] = cur[c];
   end

   assign frame_tick = frame_tick_q;
   assign settled    = (state_q == S_IDLE);
   assign unknown    = unknown_q;
   assign timeout    = timeout_q;

endmodule

// File: tb/tb_gesture_pose_sequencer.sv
// Directed bench for gesture_pose_sequencer with a 10-cycle frame and a
// 4-frame timeout; expected widths are worked out by hand from the pose table.
module tb_gesture_pose_sequencer;

   logic        clk = 1'b0;
   logic        rst;
   logic        gesture_valid;
   logic [7:0]  gesture;
   logic        gesture_ready;
   logic        tbl_we;
   logic [2:0]  tbl_idx;
   logic [2:0]  tbl_ch;
   logic [15:0] tbl_width;
   logic [79:0] width_us;
   logic        frame_tick;
   logic        settled;
   logic        unknown;
   logic        timeout;

   int checks = 0;
   int errors = 0;

   gesture_pose_sequencer #(
      .CLK_HZ         (1_000_000),
      .FRAME_US       (10),
      .STEP_US        (10),
      .TIMEOUT_FRAMES (4)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .gesture_valid (gesture_valid),
      .gesture       (gesture),
      .gesture_ready (gesture_ready),
      .tbl_we        (tbl_we),
      .tbl_idx       (tbl_idx),
      .tbl_ch        (tbl_ch),
      .tbl_width     (tbl_width),
      .width_us      (width_us),
      .frame_tick    (frame_tick),
      .settled       (settled),
      .unknown       (unknown),
      .timeout       (timeout)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [79:0] got, input logic [79:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("[TB] FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Present one gesture for a single accepting edge.
   task automatic applyStimulus(input logic [7:0] code);
      @(negedge clk);
      gesture_valid = 1'b1;
      gesture       = code;
      @(posedge clk);
      #1;
      gesture_valid = 1'b0;
   endtask

   // Wait for a frame tick, then return just after the edge that slews.
   task automatic waitTick();
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 40 && !seen; i++) begin
         @(negedge clk);
         if (frame_tick) seen = 1'b1;
      end
      checkOutput("tick_wait", {79'b0, seen}, 80'd1);
      @(posedge clk);
      #1;
   endtask

   function automatic logic [79:0] all5(input int w);
      logic [15:0] v;
      v = 16'(w);
      return {v, v, v, v, v};
   endfunction

   // Expected widths k ticks after gesture 1 following the row 1/ch 4 write.
   function automatic logic [79:0] tblExp(input int k);
      int lo, hi;
      lo = (1500 - 10 * k < 1400) ? 1400 : 1500 - 10 * k;
`ifdef GESTURE_TABLE_WR_EN
      hi = (1500 + 10 * k > 2000) ? 2000 : 1500 + 10 * k;
`else
      hi = lo;
`endif
      return {16'(hi), 16'(lo), 16'(lo), 16'(lo), 16'(lo)};
   endfunction

`ifdef GESTURE_TABLE_WR_EN
   localparam int NTBL = 50;
`else
   localparam int NTBL = 10;
`endif

   initial begin
      rst           = 1'b1;
      gesture_valid = 1'b0;
      gesture       = 8'd0;
      tbl_we        = 1'b0;
      tbl_idx       = 3'd0;
      tbl_ch        = 3'd0;
      tbl_width     = 16'd0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      #1;
      checkOutput("rst_width", width_us, all5(1500));
      checkOutput("rst_settled", {79'b0, settled}, 80'd1);
      checkOutput("rst_ready", {79'b0, gesture_ready}, 80'd1);
      checkOutput("rst_unknown", {79'b0, unknown}, 80'd0);
      checkOutput("rst_timeout", {79'b0, timeout}, 80'd0);
      checkOutput("rst_tick", {79'b0, frame_tick}, 80'd0);

      // Gesture 2 ramps every channel down to 1300, re-sent to stay active.
      applyStimulus(8'd2);
      checkOutput("load_ready", {79'b0, gesture_ready}, 80'd0);
      checkOutput("load_settled", {79'b0, settled}, 80'd0);
      for (int k = 1; k <= 20; k++) begin
         waitTick();
         checkOutput("ramp_down", width_us, all5(1500 - 10 * k));
         if (k < 20) applyStimulus(8'd2);
      end
      checkOutput("ramp_end_busy", {79'b0, settled}, 80'd0);
      @(posedge clk);
      #1;
      checkOutput("ramp_settled", {79'b0, settled}, 80'd1);
      checkOutput("ramp_unknown", {79'b0, unknown}, 80'd0);

      // One tick has already passed since the last accept; three more time out.
      for (int i = 1; i <= 3; i++) begin
         waitTick();
         checkOutput("tmo_flag", {79'b0, timeout}, (i == 3) ? 80'd1 : 80'd0);
         checkOutput("tmo_hold", width_us, all5(1300));
      end
      for (int k = 1; k <= 20; k++) begin
         waitTick();
         checkOutput("tmo_ramp", width_us, all5(1300 + 10 * k));
      end
      @(posedge clk);
      #1;
      checkOutput("tmo_settled", {79'b0, settled}, 80'd1);
      checkOutput("tmo_sticky", {79'b0, timeout}, 80'd1);
      applyStimulus(8'd0);
      checkOutput("tmo_clear", {79'b0, timeout}, 80'd0);
      @(posedge clk);
      #1;
      checkOutput("g0_settled", {79'b0, settled}, 80'd1);

      // Unknown code retargets to neutral, which is where we already are.
      applyStimulus(8'd200);
      checkOutput("unk_flag", {79'b0, unknown}, 80'd1);
      @(posedge clk);
      #1;
      checkOutput("unk_settled", {79'b0, settled}, 80'd1);
      waitTick();
      checkOutput("unk_width", width_us, all5(1500));

      // Gesture 3 down to 1450, then gesture 0 reverses the ramp.
      applyStimulus(8'd3);
      checkOutput("g3_unknown", {79'b0, unknown}, 80'd0);
      for (int k = 1; k <= 5; k++) begin
         waitTick();
         checkOutput("g3_ramp", width_us, all5(1500 - 10 * k));
         if (k < 5) applyStimulus(8'd3);
      end
      applyStimulus(8'd0);
      for (int k = 1; k <= 5; k++) begin
         waitTick();
         checkOutput("rev_ramp", width_us, all5(1450 + 10 * k));
         if (k < 5) applyStimulus(8'd0);
      end
      @(posedge clk);
      #1;
      checkOutput("rev_settled", {79'b0, settled}, 80'd1);
      checkOutput("rev_timeout", {79'b0, timeout}, 80'd0);

      // Asynchronous reset in the middle of a ramp snaps back to neutral.
      applyStimulus(8'd7);
      waitTick();
      checkOutput("g7_step", width_us, all5(1490));
      @(negedge clk);
      rst = 1'b1;
      #1;
      checkOutput("arst_width", width_us, all5(1500));
      checkOutput("arst_settled", {79'b0, settled}, 80'd1);
      checkOutput("arst_ready", {79'b0, gesture_ready}, 80'd1);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;

      // Over-range write to row 1 channel 4, then gesture 1.
      @(negedge clk);
      tbl_we    = 1'b1;
      tbl_idx   = 3'd1;
      tbl_ch    = 3'd4;
      tbl_width = 16'd2500;
      @(posedge clk);
      #1;
      tbl_we = 1'b0;
      applyStimulus(8'd1);
      for (int k = 1; k <= NTBL; k++) begin
         waitTick();
         checkOutput("tbl_ramp", width_us, tblExp(k));
         if (k < NTBL) applyStimulus(8'd1);
      end
      @(posedge clk);
      #1;
      checkOutput("tbl_settled", {79'b0, settled}, 80'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("[TB] FAIL global_timeout got=running exp=finished");
      $fatal(1, "[TB] simulation time limit reached");
   end

endmodule
